// File: rtl/wide_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// wide_mem_arbiter_if
//   Tagged wide-memory channel bundle. It carries a command channel, a
//   write-data channel and a response channel. The same interface describes
//   a client link and the memory-side link. The two links differ only in
//   TAG_W.
//
//   Parameters:
//     ADDR_W  command address width
//     DATA_W  data beat width (write data and response data)
//     TAG_W   command/response tag width
//
//   Modports:
//     master  the issuer of commands and write data, and the consumer of
//             responses (a client, or the arbiter toward memory)
//     slave   the acceptor of commands and write data, and the producer of
//             responses (the arbiter toward a client, or the memory)
// -----------------------------------------------------------------------------
interface wide_mem_arbiter_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 128,
  parameter int TAG_W  = 5
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [TAG_W-1:0]  cmd_tag;
  logic              cmd_rw;

  logic              data_valid;
  logic              data_ready;
  logic [DATA_W-1:0] data_bits;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [TAG_W-1:0]  resp_tag;

  modport master (
    output cmd_valid, cmd_addr, cmd_tag, cmd_rw,
    output data_valid, data_bits,
    output resp_ready,
    input  cmd_ready, data_ready,
    input  resp_valid, resp_data, resp_tag
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_tag, cmd_rw,
    input  data_valid, data_bits,
    input  resp_ready,
    output cmd_ready, data_ready,
    output resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/wide_mem_arbiter.sv
// -----------------------------------------------------------------------------
// wide_mem_arbiter
//   Shares one wide, tagged memory port between two clients. Client 0 is the
//   narrow-link deserializer and client 1 is a second wide master.
//
//   Arbitration works on whole transactions and alternates round-robin
//   between the clients. A transaction is one command, plus its full write
//   burst of BURST_BEATS beats when the command is a write. The granted
//   client ID is stamped into the MSB of the memory tag. Responses are routed
//   back by that bit over a purely combinational path, which runs
//   independently of the command state machine.
//
//   Ports:
//     clk, reset      clock and synchronous active-high reset
//     c0, c1          client links (slave side of wide_mem_arbiter_if)
//     mem             memory link (master side, tag width CTAG_W+1)
//     perf_grant0/1   accepted memory commands per client
//     perf_stall      cycles the granted command is held off by memory
//
//   Optional feature (macro WIDE_MEM_ARB_PERF_EN):
//     When the macro is defined, the three perf outputs are 16-bit saturating
//     counters that are cleared by reset. When it is undefined, they are tied
//     to zero and no counter flops are built.
// -----------------------------------------------------------------------------
module wide_mem_arbiter #(
  parameter int ADDR_W      = 26,
  parameter int DATA_W      = 128,
  parameter int CTAG_W      = 5,
  parameter int BURST_BEATS = 4
) (
  input  logic                clk,
  input  logic                reset,
  wide_mem_arbiter_if.slave   c0,
  wide_mem_arbiter_if.slave   c1,
  wide_mem_arbiter_if.master  mem,
  output logic [15:0]         perf_grant0,
  output logic [15:0]         perf_grant1,
  output logic [15:0]         perf_stall
);

  localparam int                BEAT_W    = $clog2(BURST_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_grant;
  logic              r_last_grant;
  logic [BEAT_W-1:0] r_beat_cnt;

  logic              w_in_cmd;
  logic              w_in_data;
  logic              w_any_req;
  logic              w_pick;
  logic              w_g_cmd_valid;
  logic              w_g_rw;
  logic [ADDR_W-1:0] w_g_addr;
  logic [CTAG_W-1:0] w_g_tag;
  logic              w_g_data_valid;
  logic [DATA_W-1:0] w_g_bits;
  logic              w_cmd_hs;
  logic              w_data_hs;
  logic              w_resp_sel;

  // Phase qualifiers are forced low during reset. Because reset is
  // synchronous, the state register may still read CMD/DATA in the reset
  // cycle, and no handshake may leak out then.
  assign w_in_cmd  = (r_state == S_CMD)  && !reset;
  assign w_in_data = (r_state == S_DATA) && !reset;

  // On a tie, the client that did not win last time is picked.
  assign w_any_req = c0.cmd_valid || c1.cmd_valid;
  assign w_pick    = (c0.cmd_valid && c1.cmd_valid) ? ~r_last_grant : c1.cmd_valid;

  // Fields of the granted client.
  assign w_g_cmd_valid  = r_grant ? c1.cmd_valid  : c0.cmd_valid;
  assign w_g_rw         = r_grant ? c1.cmd_rw     : c0.cmd_rw;
  assign w_g_addr       = r_grant ? c1.cmd_addr   : c0.cmd_addr;
  assign w_g_tag        = r_grant ? c1.cmd_tag    : c0.cmd_tag;
  assign w_g_data_valid = r_grant ? c1.data_valid : c0.data_valid;
  assign w_g_bits       = r_grant ? c1.data_bits  : c0.data_bits;

  // Memory command and write-data channels.
  assign mem.cmd_valid  = w_in_cmd && w_g_cmd_valid;
  assign mem.cmd_addr   = w_g_addr;
  assign mem.cmd_tag    = {r_grant, w_g_tag};
  assign mem.cmd_rw     = w_g_rw;
  assign mem.data_valid = w_in_data && w_g_data_valid;
  assign mem.data_bits  = w_g_bits;

  assign c0.cmd_ready  = w_in_cmd  && !r_grant && mem.cmd_ready;
  assign c1.cmd_ready  = w_in_cmd  &&  r_grant && mem.cmd_ready;
  assign c0.data_ready = w_in_data && !r_grant && mem.data_ready;
  assign c1.data_ready = w_in_data &&  r_grant && mem.data_ready;

  assign w_cmd_hs  = mem.cmd_valid  && mem.cmd_ready;
  assign w_data_hs = mem.data_valid && mem.data_ready;

  // The response path steers by the stamped tag MSB and ignores the FSM.
  // Data and tag are broadcast to both clients; only the valid is steered.
  assign w_resp_sel     = mem.resp_tag[CTAG_W];
  assign c0.resp_valid  = mem.resp_valid && !w_resp_sel;
  assign c1.resp_valid  = mem.resp_valid &&  w_resp_sel;
  assign c0.resp_data   = mem.resp_data;
  assign c1.resp_data   = mem.resp_data;
  assign c0.resp_tag    = mem.resp_tag[CTAG_W-1:0];
  assign c1.resp_tag    = mem.resp_tag[CTAG_W-1:0];
  assign mem.resp_ready = w_resp_sel ? c1.resp_ready : c0.resp_ready;

  // Transaction sequencer. IDLE is a one-cycle arbitration bubble. CMD holds
  // the grant until the command handshake completes. DATA holds it for the
  // whole write burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_beat_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_state      <= S_CMD;
          end
        end
        S_CMD: begin
          if (w_cmd_hs) begin
            r_beat_cnt <= '0;
            r_state    <= w_g_rw ? S_DATA : S_IDLE;
          end
        end
        S_DATA: begin
          if (w_data_hs) begin
            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            if (r_beat_cnt == LAST_BEAT) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef WIDE_MEM_ARB_PERF_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] r_perf_grant0;
  logic [15:0] r_perf_grant1;
  logic [15:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_grant0 <= '0;
      r_perf_grant1 <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_cmd_hs && !r_grant) r_perf_grant0 <= sat_inc16(r_perf_grant0);
      if (w_cmd_hs &&  r_grant) r_perf_grant1 <= sat_inc16(r_perf_grant1);
      if (mem.cmd_valid && !mem.cmd_ready) r_perf_stall <= sat_inc16(r_perf_stall);
    end
  end

  assign perf_grant0 = r_perf_grant0;
  assign perf_grant1 = r_perf_grant1;
  assign perf_stall  = r_perf_stall;
`else
  assign perf_grant0 = 16'h0;
  assign perf_grant1 = 16'h0;
  assign perf_stall  = 16'h0;
`endif

endmodule

// File: tb/tb_wide_mem_arbiter.sv
module tb_wide_mem_arbiter;
  localparam int ADDR_W      = 26;
  localparam int DATA_W      = 128;
  localparam int CTAG_W      = 5;
  localparam int BURST_BEATS = 4;
  localparam int MTAG_W      = CTAG_W + 1;
  localparam int TIMEOUT     = 200;
  localparam int N_RAND      = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wide_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(CTAG_W)) c0_if ();
  wide_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(CTAG_W)) c1_if ();
  wide_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(MTAG_W)) mem_if ();

  logic [15:0] perf_grant0, perf_grant1, perf_stall;

  wide_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CTAG_W(CTAG_W), .BURST_BEATS(BURST_BEATS)
  ) dut (
    .clk(clk), .reset(reset),
    .c0(c0_if), .c1(c1_if), .mem(mem_if),
    .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
  );

  // Client-side drives, indexed by client ID.
  logic              t_cmd_valid [2];
  logic [ADDR_W-1:0] t_cmd_addr  [2];
  logic [CTAG_W-1:0] t_cmd_tag   [2];
  logic              t_cmd_rw    [2];
  logic              t_data_valid[2];
  logic [DATA_W-1:0] t_data_bits [2];
  logic              t_resp_ready[2];
  logic              w_cmd_ready [2];
  logic              w_data_ready[2];
  logic              w_resp_valid[2];
  logic [DATA_W-1:0] w_resp_data [2];
  logic [CTAG_W-1:0] w_resp_tag  [2];

  // Memory-side drives.
  logic              m_cmd_ready, m_data_ready, m_resp_valid;
  logic [DATA_W-1:0] m_resp_data;
  logic [MTAG_W-1:0] m_resp_tag;

  assign c0_if.cmd_valid  = t_cmd_valid[0];   assign c1_if.cmd_valid  = t_cmd_valid[1];
  assign c0_if.cmd_addr   = t_cmd_addr[0];    assign c1_if.cmd_addr   = t_cmd_addr[1];
  assign c0_if.cmd_tag    = t_cmd_tag[0];     assign c1_if.cmd_tag    = t_cmd_tag[1];
  assign c0_if.cmd_rw     = t_cmd_rw[0];      assign c1_if.cmd_rw     = t_cmd_rw[1];
  assign c0_if.data_valid = t_data_valid[0];  assign c1_if.data_valid = t_data_valid[1];
  assign c0_if.data_bits  = t_data_bits[0];   assign c1_if.data_bits  = t_data_bits[1];
  assign c0_if.resp_ready = t_resp_ready[0];  assign c1_if.resp_ready = t_resp_ready[1];
  assign w_cmd_ready[0]   = c0_if.cmd_ready;  assign w_cmd_ready[1]   = c1_if.cmd_ready;
  assign w_data_ready[0]  = c0_if.data_ready; assign w_data_ready[1]  = c1_if.data_ready;
  assign w_resp_valid[0]  = c0_if.resp_valid; assign w_resp_valid[1]  = c1_if.resp_valid;
  assign w_resp_data[0]   = c0_if.resp_data;  assign w_resp_data[1]   = c1_if.resp_data;
  assign w_resp_tag[0]    = c0_if.resp_tag;   assign w_resp_tag[1]    = c1_if.resp_tag;
  assign mem_if.cmd_ready  = m_cmd_ready;
  assign mem_if.data_ready = m_data_ready;
  assign mem_if.resp_valid = m_resp_valid;
  assign mem_if.resp_data  = m_resp_data;
  assign mem_if.resp_tag   = m_resp_tag;

  typedef struct {
    logic [MTAG_W-1:0] tag;
    logic [ADDR_W-1:0] addr;
    logic              rw;
  } cmd_rec_t;

  typedef struct {
    logic [DATA_W-1:0] bits;
    int                ncmd;   // memory commands accepted before this beat
  } data_rec_t;

  typedef struct {
    logic                                  rw;
    logic [ADDR_W-1:0]                     addr;
    logic [CTAG_W-1:0]                     tag;
    logic [BURST_BEATS-1:0][DATA_W-1:0]    beats;
  } txn_t;

  cmd_rec_t  cmd_log[$];
  data_rec_t data_log[$];
  txn_t      q0[$], q1[$];

  int n_checks = 0;
  int n_fail   = 0;
  logic resp_chk = 1'b0;
  logic rnd_on   = 1'b0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory-side observer: log every accepted command and data beat.
  always @(negedge clk) begin
    if (mem_if.cmd_valid && mem_if.cmd_ready)
      cmd_log.push_back('{tag: mem_if.cmd_tag, addr: mem_if.cmd_addr, rw: mem_if.cmd_rw});
    if (mem_if.data_valid && mem_if.data_ready)
      data_log.push_back('{bits: mem_if.data_bits, ncmd: cmd_log.size()});
  end

  // Response routing model: the steering bit picks the client, and data/tag
  // are broadcast to both clients.
  always @(negedge clk) begin
    if (resp_chk) begin
      logic s;
      s = m_resp_tag[CTAG_W];
      check("resp_valid0", w_resp_valid[0], m_resp_valid && !s);
      check("resp_valid1", w_resp_valid[1], m_resp_valid && s);
      check("resp_ready",  mem_if.resp_ready, t_resp_ready[s]);
      check("resp_tag0",   w_resp_tag[0], m_resp_tag[CTAG_W-1:0]);
      check("resp_tag1",   w_resp_tag[1], m_resp_tag[CTAG_W-1:0]);
      check("resp_data0",  w_resp_data[0], m_resp_data);
      check("resp_data1",  w_resp_data[1], m_resp_data);
    end
  end

  task automatic drive_idle();
    for (int i = 0; i < 2; i++) begin
      t_cmd_valid[i] = 1'b0; t_cmd_addr[i] = '0; t_cmd_tag[i] = '0; t_cmd_rw[i] = 1'b0;
      t_data_valid[i] = 1'b0; t_data_bits[i] = '0; t_resp_ready[i] = 1'b0;
    end
    m_cmd_ready = 1'b1; m_data_ready = 1'b1;
    m_resp_valid = 1'b0; m_resp_data = '0; m_resp_tag = '0;
  endtask

  // Reset with live requests present, so the outputs must be held off by reset itself.
  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    t_cmd_valid[0] = 1'b1; t_cmd_valid[1] = 1'b1;
    t_data_valid[0] = 1'b1; t_data_valid[1] = 1'b1;
    tick(); tick();
    check("rst_mem_cmd_valid",  mem_if.cmd_valid, 1'b0);
    check("rst_mem_data_valid", mem_if.data_valid, 1'b0);
    check("rst_cmd_ready0",  w_cmd_ready[0], 1'b0);
    check("rst_cmd_ready1",  w_cmd_ready[1], 1'b0);
    check("rst_data_ready0", w_data_ready[0], 1'b0);
    check("rst_data_ready1", w_data_ready[1], 1'b0);
    check("rst_perf_g0", perf_grant0, 16'h0);
    check("rst_perf_g1", perf_grant1, 16'h0);
    check("rst_perf_st", perf_stall, 16'h0);
    drive_idle();
    reset = 1'b0;
    tick();
  endtask

  // Present one command and hold it until accepted. lat counts the clock
  // edges from presentation up to and including the accepting edge.
  task automatic cl_cmd(input int id, input logic rw, input logic [ADDR_W-1:0] a,
                        input logic [CTAG_W-1:0] tg, output int lat);
    logic hs;
    t_cmd_valid[id] = 1'b1; t_cmd_rw[id] = rw; t_cmd_addr[id] = a; t_cmd_tag[id] = tg;
    lat = 0; hs = 1'b0;
    while (!hs && lat < TIMEOUT) begin
      @(negedge clk);
      hs = t_cmd_valid[id] && w_cmd_ready[id];
      tick();
      lat++;
    end
    if (!hs) check($sformatf("cmd_timeout_c%0d", id), hs, 1'b1);
    t_cmd_valid[id] = 1'b0;
  endtask

  task automatic cl_data(input int id, input logic [BURST_BEATS-1:0][DATA_W-1:0] beats,
                         input int n, input logic gaps);
    for (int b = 0; b < n; b++) begin
      logic hs;
      int   w;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin t_data_valid[id] = 1'b0; tick(); end
      end
      t_data_valid[id] = 1'b1; t_data_bits[id] = beats[b];
      hs = 1'b0; w = 0;
      while (!hs && w < TIMEOUT) begin
        @(negedge clk);
        hs = w_data_ready[id];
        tick();
        w++;
      end
      if (!hs) check($sformatf("data_timeout_c%0d", id), hs, 1'b1);
    end
    t_data_valid[id] = 1'b0;
  endtask

  task automatic run_client(input int id, input int n);
    for (int i = 0; i < n; i++) begin
      txn_t t;
      int   lat;
      t = (id == 0) ? q0[i] : q1[i];
      repeat ($urandom_range(0, 3)) tick();
      cl_cmd(id, t.rw, t.addr, t.tag, lat);
      if (t.rw) cl_data(id, t.beats, BURST_BEATS, 1'b1);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int lat, bad, guard, dp;
    int idx[2];
    logic [BURST_BEATS-1:0][DATA_W-1:0] beats;

    do_reset();

    // Single read from client 0.
    cmd_log.delete(); data_log.delete();
    cl_cmd(0, 1'b0, 26'h100, 5'd3, lat);
    check("rd_latency", lat, 2);
    check("rd_cmd_count", cmd_log.size(), 1);
    if (cmd_log.size() >= 1) begin
      check("rd_tag",  cmd_log[0].tag, 6'h03);
      check("rd_addr", cmd_log[0].addr, 26'h100);
      check("rd_rw",   cmd_log[0].rw, 1'b0);
    end
    check("rd_after_valid", mem_if.cmd_valid, 1'b0);
    check("rd_c1_ready", w_cmd_ready[1], 1'b0);
    tick();
    check("rd_idle_valid", mem_if.cmd_valid, 1'b0);

    // Client 1 write burst while a client 0 read waits.
    cmd_log.delete(); data_log.delete();
    for (int b = 0; b < BURST_BEATS; b++) beats[b] = DATA_W'(32'hA + b);
    bad = 0;
    fork
      begin
        cl_cmd(1, 1'b1, 26'h2000, 5'd5, lat);
        cl_data(1, beats, BURST_BEATS, 1'b0);
      end
      begin
        tick();
        cl_cmd(0, 1'b0, 26'h300, 5'd7, lat);
      end
      begin
        guard = 0;
        while (data_log.size() < BURST_BEATS && guard < TIMEOUT) begin
          @(negedge clk);
          if (w_cmd_ready[0]) bad++;
          guard++;
        end
      end
    join
    check("wr_c0_ready_in_burst", bad, 0);
    check("wr_cmd_count", cmd_log.size(), 2);
    check("wr_beat_count", data_log.size(), BURST_BEATS);
    if (cmd_log.size() == 2) begin
      check("wr_tag",    cmd_log[0].tag, 6'h25);
      check("wr_rw",     cmd_log[0].rw, 1'b1);
      check("wr_addr",   cmd_log[0].addr, 26'h2000);
      check("wr_c0_tag", cmd_log[1].tag, 6'h07);
    end
    for (int b = 0; b < BURST_BEATS && b < data_log.size(); b++) begin
      check($sformatf("wr_beat%0d", b), data_log[b].bits, beats[b]);
      check($sformatf("wr_beat%0d_pos", b), data_log[b].ncmd, 1);
    end

    // Fairness with both clients always requesting.
    do_reset();
    cmd_log.delete(); data_log.delete();
    fork
      for (int i = 0; i < 4; i++) cl_cmd(0, 1'b0, ADDR_W'(32'h1000 + i), CTAG_W'(i), lat);
      for (int i = 0; i < 4; i++) cl_cmd(1, 1'b0, ADDR_W'(32'h2000 + i), CTAG_W'(i + 8), lat);
    join
    check("fair_count", cmd_log.size(), 8);
    idx[0] = 0; idx[1] = 0;
    for (int i = 0; i < cmd_log.size(); i++) begin
      check($sformatf("fair_grant%0d", i), cmd_log[i].tag[CTAG_W], i % 2);
      idx[cmd_log[i].tag[CTAG_W]]++;
    end
    check("fair_n0", idx[0], 4);
    check("fair_n1", idx[1], 4);

    // Directed response routing to client 1.
    m_resp_valid = 1'b1; m_resp_tag = 6'h21; m_resp_data = rnd128();
    t_resp_ready[0] = 1'b1; t_resp_ready[1] = 1'b0;
    resp_chk = 1'b1;
    @(negedge clk);
    check("rsp_c1_valid", w_resp_valid[1], 1'b1);
    check("rsp_c0_valid", w_resp_valid[0], 1'b0);
    check("rsp_ready_lo", mem_if.resp_ready, 1'b0);
    check("rsp_c1_tag",   w_resp_tag[1], 5'd1);
    tick();
    t_resp_ready[1] = 1'b1;
    @(negedge clk);
    check("rsp_ready_hi", mem_if.resp_ready, 1'b1);
    tick();
    resp_chk = 1'b0;
    m_resp_valid = 1'b0;

    // Reset in the middle of a write burst.
    for (int b = 0; b < BURST_BEATS; b++) beats[b] = rnd128();
    cl_cmd(1, 1'b1, 26'h40, 5'd2, lat);
    cl_data(1, beats, 2, 1'b0);
    t_data_valid[1] = 1'b1; t_data_bits[1] = beats[2];
    reset = 1'b1;
    @(negedge clk);
    check("mrst_dv_in_reset", mem_if.data_valid, 1'b0);
    check("mrst_dr_in_reset", w_data_ready[1], 1'b0);
    tick();
    reset = 1'b0;
    check("mrst_dv_next", mem_if.data_valid, 1'b0);
    tick();
    check("mrst_dv_idle", mem_if.data_valid, 1'b0);
    t_data_valid[1] = 1'b0;
    cmd_log.delete(); data_log.delete();
    fork
      cl_cmd(0, 1'b0, 26'h50, 5'd4, lat);
      cl_cmd(1, 1'b0, 26'h60, 5'd6, lat);
    join
    check("mrst_count", cmd_log.size(), 2);
    if (cmd_log.size() == 2) begin
      check("mrst_first_c0", cmd_log[0].tag, 6'h04);
      check("mrst_second_c1", cmd_log[1].tag, 6'h26);
    end

    // Randomised traffic on both clients, with random memory back-pressure
    // and random responses.
    do_reset();
    cmd_log.delete(); data_log.delete(); q0.delete(); q1.delete();
    for (int i = 0; i < N_RAND; i++) begin
      txn_t t;
      for (int c = 0; c < 2; c++) begin
        t.rw = 1'($urandom_range(0, 1));
        t.addr = ADDR_W'($urandom);
        t.tag = CTAG_W'($urandom);
        for (int b = 0; b < BURST_BEATS; b++) t.beats[b] = rnd128();
        if (c == 0) q0.push_back(t); else q1.push_back(t);
      end
    end
    rnd_on = 1'b1; resp_chk = 1'b1;
    fork
      begin
        fork
          run_client(0, N_RAND);
          run_client(1, N_RAND);
        join
        rnd_on = 1'b0;
      end
      while (rnd_on) begin
        m_cmd_ready  = ($urandom_range(0, 9) < 7);
        m_data_ready = ($urandom_range(0, 9) < 7);
        m_resp_valid = 1'($urandom_range(0, 1));
        m_resp_tag   = MTAG_W'($urandom);
        m_resp_data  = rnd128();
        t_resp_ready[0] = 1'($urandom_range(0, 1));
        t_resp_ready[1] = 1'($urandom_range(0, 1));
        tick();
      end
    join
    resp_chk = 1'b0;
    drive_idle();
    check("rnd_cmd_count", cmd_log.size(), 2 * N_RAND);
    idx[0] = 0; idx[1] = 0; dp = 0;
    for (int i = 0; i < cmd_log.size(); i++) begin
      int   id;
      txn_t e;
      id = int'(cmd_log[i].tag[CTAG_W]);
      if (idx[id] >= N_RAND) begin
        check($sformatf("rnd_extra_c%0d", id), idx[id], N_RAND - 1);
        continue;
      end
      e = (id == 0) ? q0[idx[id]] : q1[idx[id]];
      idx[id]++;
      check($sformatf("rnd_addr%0d", i), cmd_log[i].addr, e.addr);
      check($sformatf("rnd_tag%0d", i),  cmd_log[i].tag[CTAG_W-1:0], e.tag);
      check($sformatf("rnd_rw%0d", i),   cmd_log[i].rw, e.rw);
      if (e.rw) begin
        for (int b = 0; b < BURST_BEATS; b++) begin
          if (dp < data_log.size()) begin
            check($sformatf("rnd_beat%0d_%0d", i, b), data_log[dp].bits, e.beats[b]);
            check($sformatf("rnd_beatpos%0d_%0d", i, b), data_log[dp].ncmd, i + 1);
          end else begin
            check($sformatf("rnd_beat_missing%0d_%0d", i, b), dp, data_log.size() + 1);
          end
          dp++;
        end
      end
    end
    check("rnd_beat_total", data_log.size(), dp);

    // Performance counters: 3 client-0 and 2 client-1 commands, with the
    // first command stalled by memory for 5 cycles.
    do_reset();
    m_cmd_ready = 1'b0;
    fork
      cl_cmd(0, 1'b0, 26'h70, 5'd1, lat);
      begin
        guard = 0;
        while (!mem_if.cmd_valid && guard < TIMEOUT) begin tick(); guard++; end
        repeat (5) tick();
        m_cmd_ready = 1'b1;
      end
    join
    cl_cmd(1, 1'b0, 26'h71, 5'd2, lat);
    cl_cmd(0, 1'b0, 26'h72, 5'd3, lat);
    cl_cmd(1, 1'b0, 26'h73, 5'd4, lat);
    cl_cmd(0, 1'b0, 26'h74, 5'd5, lat);
    tick();
`ifdef WIDE_MEM_ARB_PERF_EN
    check("perf_grant0", perf_grant0, 16'd3);
    check("perf_grant1", perf_grant1, 16'd2);
    check("perf_stall",  perf_stall,  16'd5);
`else
    check("perf_grant0", perf_grant0, 16'd0);
    check("perf_grant1", perf_grant1, 16'd0);
    check("perf_stall",  perf_stall,  16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
